// File: rtl/reg_writeback_ctrl.sv
// Purpose: owns the register-file write port, merging ALU results and in-order
//          load returns, with a busy scoreboard for outstanding loads and RAW hazard detection.
// Latency: 1 cycle from acceptance to reg_write_en. Backpressure: memory beats ALU; ALU stalls on a busy rd.
// Optional: define WB_BYPASS_EN to add fwd1/fwd2 forwarding ports and drop the in-flight hazard term.
module reg_writeback_ctrl #(
  parameter int LD_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [2:0]  alu_rd,
  input  logic [9:0]  alu_data,
  output logic        alu_ready,
  input  logic        ld_issue,
  input  logic [2:0]  ld_issue_rd,
  output logic        ld_issue_ready,
  input  logic        mem_rvalid,
  input  logic [9:0]  mem_rdata,
  input  logic [2:0]  src1,
  input  logic [2:0]  src2,
  output logic        raw_hazard,
`ifdef WB_BYPASS_EN
  output logic        fwd1_sel,
  output logic [9:0]  fwd1_data,
  output logic        fwd2_sel,
  output logic [9:0]  fwd2_data,
`endif
  output logic [2:0]  write_reg,
  output logic [9:0]  write_data,
  output logic        reg_write_en,
  output logic [7:0]  busy_mask,
  output logic        resp_err
);

  localparam int PW = $clog2(LD_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(LD_DEPTH);

  // Load-tag FIFO state
  logic [2:0]    tag_q [LD_DEPTH];
  logic [2:0]    tag_d [LD_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Writeback and scoreboard state
  logic [2:0] write_reg_q, write_reg_d;
  logic [9:0] write_data_q, write_data_d;
  logic       reg_write_en_q, reg_write_en_d;
  logic [7:0] busy_q, busy_d;
  logic       resp_err_q, resp_err_d;

  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          alu_acc;
  logic [2:0]    head_tag;
  logic          still_pending;
  logic [PW-1:0] scan_idx;
  logic          wr_hit1;
  logic          wr_hit2;

  // Handshake decode: memory return preempts the ALU; a busy rd stalls the ALU for WAW order
  always_comb begin
    fifo_empty     = (cnt_q == '0);
    ld_issue_ready = (cnt_q != FULL_CNT);
    push           = ld_issue && ld_issue_ready;
    pop            = mem_rvalid && !fifo_empty;
    head_tag       = tag_q[rd_ptr_q];
    alu_ready      = !pop && !busy_q[alu_rd];
    alu_acc        = alu_valid && alu_ready;
  end

  // Does any entry behind the head (i.e. remaining after the pop) still target the head register?
  always_comb begin
    still_pending = 1'b0;
    scan_idx      = rd_ptr_q;
    for (int k = 1; k < LD_DEPTH; k++) begin
      scan_idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < cnt_q) && (tag_q[scan_idx] == head_tag)) begin
        still_pending = 1'b1;
      end
    end
  end

  // FIFO next state: push at write pointer, pop at read pointer, count tracks both
  always_comb begin
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      tag_d[wr_ptr_q] = ld_issue_rd;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Writeback select, busy scoreboard (set applied after clear so it wins) and sticky response error
  always_comb begin
    write_reg_d    = write_reg_q;
    write_data_d   = write_data_q;
    reg_write_en_d = 1'b0;
    busy_d         = busy_q;
    resp_err_d     = resp_err_q;
    if (pop) begin
      reg_write_en_d = 1'b1;
      write_reg_d    = head_tag;
      write_data_d   = mem_rdata;
      if (!still_pending) begin
        busy_d[head_tag] = 1'b0;
      end
    end else if (alu_acc) begin
      reg_write_en_d = 1'b1;
      write_reg_d    = alu_rd;
      write_data_d   = alu_data;
    end
    if (push) begin
      busy_d[ld_issue_rd] = 1'b1;
    end
    if (mem_rvalid && fifo_empty) begin
      resp_err_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LD_DEPTH; i++) begin
        tag_q[i] <= '0;
      end
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      write_reg_q    <= '0;
      write_data_q   <= '0;
      reg_write_en_q <= 1'b0;
      busy_q         <= '0;
      resp_err_q     <= 1'b0;
    end else begin
      tag_q          <= tag_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
      write_reg_q    <= write_reg_d;
      write_data_q   <= write_data_d;
      reg_write_en_q <= reg_write_en_d;
      busy_q         <= busy_d;
      resp_err_q     <= resp_err_d;
    end
  end

  // Hazard and optional forwarding; the regfile is written at the edge but read combinationally
  always_comb begin
    wr_hit1 = reg_write_en_q && (write_reg_q == src1);
    wr_hit2 = reg_write_en_q && (write_reg_q == src2);
`ifdef WB_BYPASS_EN
    fwd1_sel   = wr_hit1;
    fwd1_data  = write_data_q;
    fwd2_sel   = wr_hit2;
    fwd2_data  = write_data_q;
    raw_hazard = busy_q[src1] | busy_q[src2];
`else
    raw_hazard = busy_q[src1] | busy_q[src2] | wr_hit1 | wr_hit2;
`endif
  end

  assign write_reg    = write_reg_q;
  assign write_data   = write_data_q;
  assign reg_write_en = reg_write_en_q;
  assign busy_mask    = busy_q;
  assign resp_err     = resp_err_q;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl (default build, LD_DEPTH=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
// Every expected value below is hand-derived from the block's behaviour.
module tb_reg_writeback_ctrl;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [2:0]  alu_rd;
  logic [9:0]  alu_data;
  logic        alu_ready;
  logic        ld_issue;
  logic [2:0]  ld_issue_rd;
  logic        ld_issue_ready;
  logic        mem_rvalid;
  logic [9:0]  mem_rdata;
  logic [2:0]  src1;
  logic [2:0]  src2;
  logic        raw_hazard;
  logic [2:0]  write_reg;
  logic [9:0]  write_data;
  logic        reg_write_en;
  logic [7:0]  busy_mask;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  reg_writeback_ctrl #(.LD_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .alu_ready      (alu_ready),
    .ld_issue       (ld_issue),
    .ld_issue_rd    (ld_issue_rd),
    .ld_issue_ready (ld_issue_ready),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .src1           (src1),
    .src2           (src2),
    .raw_hazard     (raw_hazard),
    .write_reg      (write_reg),
    .write_data     (write_data),
    .reg_write_en   (reg_write_en),
    .busy_mask      (busy_mask),
    .resp_err       (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    alu_valid   = 1'b0;
    alu_rd      = 3'd0;
    alu_data    = 10'd0;
    ld_issue    = 1'b0;
    ld_issue_rd = 3'd0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 10'd0;
    src1        = 3'd0;
    src2        = 3'd0;

    // Reset held with inputs toggling: outputs must stay cleared
    for (int i = 0; i < 4; i++) begin
      alu_valid   = ~alu_valid;
      alu_rd      = 3'(i + 1);
      alu_data    = 10'h3FF ^ 10'(i);
      ld_issue    = ~ld_issue;
      ld_issue_rd = 3'(i + 2);
      mem_rvalid  = ~mem_rvalid;
      mem_rdata   = 10'h1F0 + 10'(i);
      tick();
    end
    check("rst_write_en",   32'(reg_write_en), 32'h0);
    check("rst_write_reg",  32'(write_reg),    32'h0);
    check("rst_write_data", 32'(write_data),   32'h0);
    check("rst_busy",       32'(busy_mask),    32'h0);
    check("rst_resp_err",   32'(resp_err),     32'h0);
    check("rst_ld_ready",   32'(ld_issue_ready), 32'h1);

    alu_valid  = 1'b0;
    ld_issue   = 1'b0;
    mem_rvalid = 1'b0;
    settle();
    reset = 1'b1;
    tick();
    check("idle_write_en", 32'(reg_write_en), 32'h0);

    // ALU write: rd 3, 0x155
    alu_valid = 1'b1; alu_rd = 3'd3; alu_data = 10'h155;
    settle();
    check("alu_ready_free", 32'(alu_ready), 32'h1);
    tick();
    alu_valid = 1'b0;
    check("alu_wr_en",   32'(reg_write_en), 32'h1);
    check("alu_wr_reg",  32'(write_reg),    32'h3);
    check("alu_wr_data", 32'(write_data),   32'h155);
    src1 = 3'd3; src2 = 3'd0;
    settle();
    check("haz_inflight", 32'(raw_hazard), 32'h1);
    tick();
    check("idle_en_low",   32'(reg_write_en), 32'h0);
    check("idle_reg_hold", 32'(write_reg),    32'h3);
    check("idle_dat_hold", 32'(write_data),   32'h155);
    check("haz_cleared",   32'(raw_hazard),   32'h0);

    // Load rd 5, return two cycles later with 0x2AA
    ld_issue = 1'b1; ld_issue_rd = 3'd5;
    tick();
    ld_issue = 1'b0;
    src1 = 3'd5;
    settle();
    check("ld_busy",    32'(busy_mask),  32'h20);
    check("ld_haz",     32'(raw_hazard), 32'h1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 10'h2AA;
    settle();
    check("ld_ret_alu_blocked", 32'(alu_ready), 32'h0);
    tick();
    mem_rvalid = 1'b0;
    src1 = 3'd0;
    check("ld_wr_en",   32'(reg_write_en), 32'h1);
    check("ld_wr_reg",  32'(write_reg),    32'h5);
    check("ld_wr_data", 32'(write_data),   32'h2AA);
    check("ld_busy_clr", 32'(busy_mask),   32'h0);

    // Conflict: return tag 2 (0x011) and ALU rd 4 (0x022) together
    ld_issue = 1'b1; ld_issue_rd = 3'd2;
    tick();
    ld_issue = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 10'h011;
    alu_valid = 1'b1; alu_rd = 3'd4; alu_data = 10'h022;
    settle();
    check("cf_alu_ready0", 32'(alu_ready), 32'h0);
    tick();
    mem_rvalid = 1'b0;
    check("cf_first_reg",  32'(write_reg),  32'h2);
    check("cf_first_data", 32'(write_data), 32'h011);
    settle();
    check("cf_alu_ready1", 32'(alu_ready), 32'h1);
    tick();
    alu_valid = 1'b0;
    check("cf_second_en",   32'(reg_write_en), 32'h1);
    check("cf_second_reg",  32'(write_reg),    32'h4);
    check("cf_second_data", 32'(write_data),   32'h022);

    // WAW stall: load rd 6 outstanding, ALU rd 6 waits
    ld_issue = 1'b1; ld_issue_rd = 3'd6;
    tick();
    ld_issue = 1'b0;
    alu_valid = 1'b1; alu_rd = 3'd6; alu_data = 10'h0AB;
    settle();
    check("waw_stall_a", 32'(alu_ready), 32'h0);
    tick();
    check("waw_stall_b", 32'(alu_ready),    32'h0);
    check("waw_no_wr",   32'(reg_write_en), 32'h0);
    mem_rvalid = 1'b1; mem_rdata = 10'h3C3;
    tick();
    mem_rvalid = 1'b0;
    check("waw_ld_reg",  32'(write_reg),  32'h6);
    check("waw_ld_data", 32'(write_data), 32'h3C3);
    check("waw_busy",    32'(busy_mask),  32'h0);
    settle();
    check("waw_release", 32'(alu_ready), 32'h1);
    tick();
    alu_valid = 1'b0;
    check("waw_alu_en",   32'(reg_write_en), 32'h1);
    check("waw_alu_reg",  32'(write_reg),    32'h6);
    check("waw_alu_data", 32'(write_data),   32'h0AB);

    // Full FIFO: two loads to rd 1, third issue ignored
    ld_issue = 1'b1; ld_issue_rd = 3'd1;
    tick();
    settle();
    check("full_ready_one", 32'(ld_issue_ready), 32'h1);
    tick();
    ld_issue_rd = 3'd7;
    settle();
    check("full_ready0", 32'(ld_issue_ready), 32'h0);
    check("full_busy",   32'(busy_mask),      32'h02);
    tick();
    ld_issue = 1'b0;
    check("full_ignored", 32'(busy_mask), 32'h02);
    mem_rvalid = 1'b1; mem_rdata = 10'h101;
    tick();
    check("full_r1_data", 32'(write_data), 32'h101);
    check("full_r1_busy", 32'(busy_mask),  32'h02);
    check("full_r1_rdy",  32'(ld_issue_ready), 32'h1);
    mem_rdata = 10'h102;
    tick();
    mem_rvalid = 1'b0;
    check("full_r2_reg",  32'(write_reg),  32'h1);
    check("full_r2_data", 32'(write_data), 32'h102);
    check("full_r2_busy", 32'(busy_mask),  32'h00);
    tick();
    check("full_idle_en", 32'(reg_write_en), 32'h0);

    // Same-cycle issue and return to the same register: set wins
    ld_issue = 1'b1; ld_issue_rd = 3'd3;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 10'h0F0;
    tick();
    ld_issue = 1'b0;
    check("sim_busy_kept", 32'(busy_mask),  32'h08);
    check("sim_data",      32'(write_data), 32'h0F0);
    check("sim_ready",     32'(ld_issue_ready), 32'h1);
    mem_rdata = 10'h0F1;
    tick();
    mem_rvalid = 1'b0;
    check("sim_busy_clr", 32'(busy_mask),  32'h00);
    check("sim_data2",    32'(write_data), 32'h0F1);

    // Unexpected response: sticky error, no write
    tick();
    check("err_pre", 32'(resp_err), 32'h0);
    mem_rvalid = 1'b1; mem_rdata = 10'h3AA;
    tick();
    mem_rvalid = 1'b0;
    check("err_set",   32'(resp_err),     32'h1);
    check("err_no_wr", 32'(reg_write_en), 32'h0);
    tick();
    tick();
    check("err_sticky", 32'(resp_err), 32'h1);
    reset = 1'b0;
    settle();
    check("err_rst_clr", 32'(resp_err), 32'h0);
    reset = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound so the run always ends
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
